// File: rtl/traffic_pkg.sv
// Shared definitions for the junction scheduler and the light controller.
// Holds the phase encoding and the default timing constants.
package traffic_pkg;

  typedef enum logic [1:0] {
    SERVE_A   = 2'd0,
    CHANGE_AB = 2'd1,
    SERVE_B   = 2'd2,
    CHANGE_BA = 2'd3
  } phase_t;

  localparam int MIN_GREEN_DEF    = 4;
  localparam int MAX_GREEN_DEF    = 12;
  localparam int CHANGE_TICKS_DEF = 6;
  localparam int CNT_W_DEF        = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// Up/down counter that saturates at all-ones and floors at zero.
// Simultaneous inc and dec cancel.
module sat_updown_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Right-of-way scheduler for a two-road junction: queue tracking, min/max green
// enforcement and a fixed change-over hold while the light FSM shows yellow.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN    = MIN_GREEN_DEF,
  parameter int MAX_GREEN    = MAX_GREEN_DEF,
  parameter int CHANGE_TICKS = CHANGE_TICKS_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             arrive_a,
  input  logic             arrive_b,
  input  logic             depart_a,
  input  logic             depart_b,
  output logic             grant_a,
  output logic             changing,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] q_a,
  output logic [CNT_W-1:0] q_b
);

  localparam int TMR_MAX = max2(MAX_GREEN, CHANGE_TICKS);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] MIN_T = TMR_W'(MIN_GREEN);
  localparam logic [TMR_W-1:0] MAX_T = TMR_W'(MAX_GREEN);
  localparam logic [TMR_W-1:0] CHG_T = TMR_W'(CHANGE_TICKS);
  localparam logic [TMR_W-1:0] TOP_T = TMR_W'(TMR_MAX);

  if (!((MIN_GREEN >= 1) && (MIN_GREEN <= MAX_GREEN) && (CHANGE_TICKS >= 1) &&
        (MAX_GREEN < (2 ** TMR_W)))) begin : g_bad_params
    $error("traffic_phase_scheduler: illegal timing parameters");
  end

  phase_t           phase_q, phase_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [TMR_W-1:0] timer_lim;
  logic             grant_q, grant_d;
  logic             chg_q, chg_d;
  logic             a_wait, b_wait;

  sat_updown_counter #(.WIDTH(CNT_W)) u_cnt_a (
    .clk (clk),
    .rst (rst),
    .inc (arrive_a),
    .dec (depart_a),
    .q   (q_a)
  );

  sat_updown_counter #(.WIDTH(CNT_W)) u_cnt_b (
    .clk (clk),
    .rst (rst),
    .inc (arrive_b),
    .dec (depart_b),
    .q   (q_b)
  );

  assign a_wait = (q_a != '0);
  assign b_wait = (q_b != '0);

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      SERVE_A:   if (b_wait && (timer_q >= MIN_T) && (!a_wait || (timer_q >= MAX_T)))
                   phase_d = CHANGE_AB;
      CHANGE_AB: if (timer_q == CHG_T) phase_d = SERVE_B;
      SERVE_B:   if (a_wait && (timer_q >= MIN_T) && (!b_wait || (timer_q >= MAX_T)))
                   phase_d = CHANGE_BA;
      CHANGE_BA: if (timer_q == CHG_T) phase_d = SERVE_A;
      default:   phase_d = SERVE_A;
    endcase

    // Change-overs may need to count past MAX_GREEN if CHANGE_TICKS is larger.
    timer_lim = phase_q[0] ? TOP_T : MAX_T;
    timer_d   = timer_q;
    if (phase_d != phase_q) begin
      timer_d = '0;
    end else if (tick && (timer_q < timer_lim)) begin
      timer_d = timer_q + TMR_W'(1);
    end

    grant_d = (phase_d == SERVE_A) || (phase_d == CHANGE_BA);
    chg_d   = phase_d[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= SERVE_A;
      timer_q <= '0;
      grant_q <= 1'b1;
      chg_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      timer_q <= timer_d;
      grant_q <= grant_d;
      chg_q   <= chg_d;
    end
  end

  assign phase    = phase_q;
  assign grant_a  = grant_q;
  assign changing = chg_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed scenarios plus random traffic,
// all outputs compared each cycle against a rule-level reference model.
module tb_traffic_phase_scheduler;

  localparam int MING = 4;
  localparam int MAXG = 12;
  localparam int CHGT = 6;
  localparam int QMAX = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick, arrive_a, arrive_b, depart_a, depart_b;
  logic       grant_a, changing;
  logic [1:0] phase;
  logic [3:0] q_a, q_b;

  int n_vec = 0;
  int n_err = 0;

  // reference model state: phase 0..3 = A, A->B, B, B->A
  int m_phase, m_t, m_qa, m_qb;

  traffic_phase_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .arrive_a (arrive_a),
    .arrive_b (arrive_b),
    .depart_a (depart_a),
    .depart_b (depart_b),
    .grant_a  (grant_a),
    .changing (changing),
    .phase    (phase),
    .q_a      (q_a),
    .q_b      (q_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int q_next(input int q, input bit arr, input bit dep);
    if (arr && !dep) return (q < QMAX) ? q + 1 : QMAX;
    if (dep && !arr) return (q > 0) ? q - 1 : 0;
    return q;
  endfunction

  task automatic model_step(input bit t, input bit aa, input bit ab, input bit da, input bit db);
    int own, opp, np;
    np = m_phase;
    if (m_phase % 2 == 0) begin
      own = (m_phase == 0) ? m_qa : m_qb;
      opp = (m_phase == 0) ? m_qb : m_qa;
      if (opp > 0 && m_t >= MING && (own == 0 || m_t >= MAXG)) np = m_phase + 1;
    end else if (m_t == CHGT) begin
      np = (m_phase + 1) % 4;
    end
    if (np != m_phase) m_t = 0;
    else if (t && m_t < MAXG) m_t = m_t + 1;
    m_phase = np;
    m_qa = q_next(m_qa, aa, da);
    m_qb = q_next(m_qb, ab, db);
  endtask

  task automatic compare_all();
    check("phase", int'(phase), m_phase);
    check("grant_a", int'(grant_a), (m_phase == 0 || m_phase == 3) ? 1 : 0);
    check("changing", int'(changing), m_phase % 2);
    check("q_a", int'(q_a), m_qa);
    check("q_b", int'(q_b), m_qb);
  endtask

  // Asynchronous reset asserted between edges; checked before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    tick = 0; arrive_a = 0; arrive_b = 0; depart_a = 0; depart_b = 0;
    #2;
    m_phase = 0; m_t = 0; m_qa = 0; m_qb = 0;
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;
  endtask

  task automatic step(input bit t, input bit aa, input bit ab, input bit da, input bit db);
    tick = t; arrive_a = aa; arrive_b = ab; depart_a = da; depart_b = db;
    @(posedge clk);
    model_step(t, aa, ab, da, db);
    #1;
    compare_all();
  endtask

  initial begin
    rst = 1'b1;
    tick = 0; arrive_a = 0; arrive_b = 0; depart_a = 0; depart_b = 0;
    @(posedge clk);
    #1;

    // idle road: 20 ticks, nothing moves
    do_reset();
    for (int k = 0; k < 20; k++) step(1, 0, 0, 0, 0);
    check("idle_phase", int'(phase), 0);
    check("idle_grant", int'(grant_a), 1);

    // one B vehicle: change-over after MIN_GREEN, SERVE_B 6 ticks later;
    // an A arrival during change-over does not abort it
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      step(1, k == 7, k == 1, 0, k == 13);
      if (k == 4)  check("minG_still_A", int'(phase), 0);
      if (k == 5)  check("minG_grant_fall", int'(grant_a), 0);
      if (k == 11) check("chg_hold", int'(changing), 1);
      if (k == 12) check("serve_b", int'(phase), 2);
      if (k == 16) check("serve_b_minG", int'(phase), 2);
      if (k == 17) check("change_ba", int'(phase), 3);
    end

    // starvation guard: A keeps 3 waiting, B must wait for MAX_GREEN
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      step(k >= 5, k <= 3, k == 4, 0, 0);
      if (k == 16) check("maxG_hold", int'(phase), 0);
      if (k == 17) check("maxG_switch", int'(phase), 1);
    end

    // queue saturation, cancel, floor
    do_reset();
    for (int k = 0; k < 16; k++) step(0, 1, 0, 0, 0);
    check("q_a_sat", int'(q_a), 15);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    check("q_a_cancel", int'(q_a), 14);
    do_reset();
    step(0, 0, 0, 1, 0);
    check("q_a_floor", int'(q_a), 0);

    // reset while serving B with 5 waiting
    do_reset();
    for (int k = 1; k <= 12; k++) step(1, 0, k <= 5, 0, 0);
    check("pre_rst_phase", int'(phase), 2);
    check("pre_rst_q_b", int'(q_b), 5);
    do_reset();
    check("post_rst_q_b", int'(q_b), 0);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(499) == 0) do_reset();
      else step($urandom_range(2) == 0, $urandom_range(3) == 0, $urandom_range(3) == 0,
                $urandom_range(4) == 0, $urandom_range(4) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
